// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_arbiter_pkg                                              |
// | Description : Shared bus constants, arbiter FSM encoding and defaults.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bus_arbiter_pkg;

    localparam int c_addr_width     = 12;
    localparam int c_data_width     = 8;
    localparam int c_hold_limit_def = 64;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant   = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_select                                                    |
// | Description : Combinational round-robin pick starting at index ptr.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_select
    import bus_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {1'b0, ptr} + (W+1)'(i);
            if (w_cand >= (W+1)'(N)) begin
                w_cand = w_cand - (W+1)'(N);
            end
            if (req[w_cand[W-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_arbiter                                                  |
// | Description : Round-robin bus arbiter with hold limit and turnaround.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int HOLD_LIMIT  = c_hold_limit_def
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         mreq,
    input  logic                           sready,
    output logic [NUM_MASTERS-1:0]         mgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] msel,
    output logic                           bbusy,
    output logic                           tout
);

    localparam int c_sel_w  = $clog2(NUM_MASTERS);
    localparam int c_hold_w = $clog2(HOLD_LIMIT);

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] r_blocked;
    logic [c_sel_w-1:0]     r_sel;
    logic [c_sel_w-1:0]     r_last;
    logic [c_hold_w-1:0]    r_hold;
    logic                   r_tout;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_win_onehot;
    logic [c_sel_w-1:0]     w_ptr;
    logic [c_sel_w-1:0]     w_win_idx;
    logic                   w_win_valid;
    logic                   w_owner_req;
    logic                   w_hold_hit;

    assign w_eligible   = mreq & ~r_blocked;
    assign w_ptr        = (r_last == c_sel_w'(NUM_MASTERS - 1)) ? '0 : r_last + 1'b1;
    assign w_win_onehot = NUM_MASTERS'(1) << w_win_idx;
    assign w_owner_req  = mreq[r_sel];
    assign w_hold_hit   = (r_hold == c_hold_w'(HOLD_LIMIT - 1));

    rr_select #(
        .N (NUM_MASTERS),
        .W (c_sel_w)
    ) u_rr_select (
        .req   (w_eligible),
        .ptr   (w_ptr),
        .valid (w_win_valid),
        .idx   (w_win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_grant   <= '0;
            r_sel     <= '0;
            r_last    <= c_sel_w'(NUM_MASTERS - 1);
            r_hold    <= '0;
            r_blocked <= '0;
            r_tout    <= 1'b0;
        end else begin
            r_tout    <= 1'b0;
            // A blocked master is released once its request is seen low.
            r_blocked <= r_blocked & mreq;
            case (r_state)
                c_st_idle: begin
                    if (w_win_valid && sready) begin
                        r_state <= c_st_grant;
                        r_grant <= w_win_onehot;
                        r_sel   <= w_win_idx;
                        r_last  <= w_win_idx;
                        r_hold  <= '0;
                    end
                end
                c_st_grant: begin
                    if (!w_owner_req) begin
                        r_state <= c_st_release;
                        r_grant <= '0;
                    end else if (w_hold_hit) begin
                        r_state   <= c_st_release;
                        r_grant   <= '0;
                        r_tout    <= 1'b1;
                        r_blocked <= (r_blocked & mreq) | r_grant;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                c_st_release: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign mgrant = r_grant;
    assign msel   = r_sel;
    assign bbusy  = |r_grant;
    assign tout   = r_tout;

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, giving the number of requesting masters (2..4).
REQ-002 The block SHALL have parameter HOLD_LIMIT, default 64, giving the maximum grant length in clk cycles (>=4).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 The block SHALL have port mreq, input, NUM_MASTERS bits: per-master bus request, level, held for the whole transaction.
REQ-006 The block SHALL have port sready, input, 1 bit: the addressed slave side is ready to accept a new transaction.
REQ-007 The block SHALL have port mgrant, output, NUM_MASTERS bits: one-hot or zero bus grant.
REQ-008 The block SHALL have port msel, output, clog2(NUM_MASTERS) bits: index of the current owner, which drives the bus mux.
REQ-009 The block SHALL have port bbusy, output, 1 bit: the bus is owned, high whenever mgrant != 0.
REQ-010 The block SHALL have port tout, output, 1 bit: a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT and RELEASE, all encoded in registers.
REQ-012 IDLE -> GRANT SHALL occur when any eligible mreq bit and sready are high; mgrant SHALL assert on the next clk edge (1-cycle latency).
REQ-013 Winner selection SHALL be round-robin: the search starts at (last_owner+1) mod NUM_MASTERS, and last_owner = NUM_MASTERS-1 after reset, so master 0 wins first.
REQ-014 In GRANT, mgrant and msel SHALL remain stable; requests from other masters SHALL NOT pre-empt the owner.
REQ-015 GRANT -> RELEASE SHALL occur when the owner's mreq drops; mgrant SHALL go to 0 on that same edge.
REQ-016 RELEASE SHALL last exactly one cycle as bus turnaround, with mgrant = 0, and then return to IDLE; no grant is possible in RELEASE.
REQ-017 A hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-018 When the hold counter reaches HOLD_LIMIT-1 with the owner's mreq still high, the FSM SHALL enter RELEASE and pulse tout for 1 cycle.
REQ-019 A master revoked by the hold limit SHALL be marked blocked and be ineligible until its mreq is observed low for at least one cycle.
REQ-020 If the owner drops mreq in the same cycle the hold limit is reached, the release SHALL be treated as normal, with no tout.
REQ-021 When mreq is high but sready is low in IDLE, the FSM SHALL stay in IDLE and mgrant SHALL stay 0.
REQ-022 When only one master requests, it SHALL win regardless of the round-robin pointer.
REQ-023 If a non-owner's mreq toggles during GRANT, it SHALL have no effect until IDLE.
REQ-024 msel SHALL hold the last owner's index while no master is granted.

Reset
REQ-025 When rst is high at a clk edge, the block SHALL enter IDLE with mgrant=0, msel=0, bbusy=0, tout=0, hold counter=0, all blocked bits=0 and last_owner=NUM_MASTERS-1.
REQ-026 A reset asserted during GRANT SHALL drop mgrant on that edge; the first grant after reset is no earlier than 1 cycle after rst deasserts.

Structure
REQ-027 The FSM state encoding and the HOLD_LIMIT default SHALL live in a shared package used alongside the bus constants (ADDR_WIDTH=12, DATA_WIDTH=8).
REQ-028 Round-robin winner selection SHALL be a sub-module rr_select, combinational, taking the request vector and pointer and returning valid and index.

Verification
REQ-029 The bench SHALL cover: reset, then mreq=2'b11 and sready=1 -> mgrant=2'b01 one cycle later, msel=0.
REQ-030 The bench SHALL cover: master 0 drops mreq while mreq[1] stays high -> 1 cycle with mgrant=0 in RELEASE, then 1 cycle in IDLE, then mgrant=2'b10.
REQ-031 The bench SHALL cover: mreq[0] held for 70 cycles with HOLD_LIMIT=64 -> grant revoked after 64 cycles, tout pulses once, and master 0 gets no regrant until its mreq toggles low.
REQ-032 The bench SHALL cover: mreq=2'b01 with sready=0 for 10 cycles -> mgrant stays 0, and it grants 1 cycle after sready rises.
REQ-033 The bench SHALL cover: rst asserted during GRANT -> mgrant=0 and bbusy=0 on the next edge, and after release master 0 wins first.
REQ-034 The bench SHALL cover: owner drops mreq on the limit cycle -> normal release with tout=0.
